pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 199 +++++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Two-entry skid buffer that sits between two pipeline stages (EX -> MEM
// style). The MAIN entry drives the outputs; the SKID entry catches one
// extra word when upstream delivers while downstream is stalled, so that
// in_ready never depends combinationally on out_ready.
//
// All state updates happen on the FALLING edge of clk. Reset is
// asynchronous and active-low on the port named "reset".
//
// Ports
//   clk            : clock, state updates on negedge
//   reset          : asynchronous active-low reset
//   db_ena         : debug clock enable, 0 freezes every register
//   flush          : synchronous discard of all buffered entries
//   in_valid/in_ready   : upstream handshake
//   in_alu, in_zero, in_addr_dest, in_wr_data, in_ctrl, in_opcode : payload
//   in_end         : end-of-program marker carried with the input
//   out_valid/out_ready : downstream handshake
//   out_alu, out_zero, out_addr_dest, out_wr_data, out_ctrl, out_opcode :
//                    payload from MAIN (out_ctrl forced to 0 on a bubble)
//   out_end        : sticky end flag, cleared only by reset
//   occupancy      : number of entries held (0..2)
//   stall_cnt      : saturating count of edges where upstream was refused
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CTRL_W  = 5,
  parameter int OP_W    = 6,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               db_ena,
  input  logic               flush,

  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic               in_zero,
  input  logic [ADDR_W-1:0]  in_addr_dest,
  input  logic [DATA_W-1:0]  in_wr_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [OP_W-1:0]    in_opcode,
  input  logic               in_end,

  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_alu,
  output logic               out_zero,
  output logic [ADDR_W-1:0]  out_addr_dest,
  output logic [DATA_W-1:0]  out_wr_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [OP_W-1:0]    out_opcode,

  output logic               out_end,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  // Payload is kept as one flat vector so MAIN and SKID share the same
  // load/move logic. Field layout, LSB first:
  //   opcode | ctrl | wr_data | addr_dest | zero | alu
  localparam int OFF_CTRL = OP_W;
  localparam int OFF_WD   = OFF_CTRL + CTRL_W;
  localparam int OFF_ADDR = OFF_WD + DATA_W;
  localparam int OFF_ZERO = OFF_ADDR + ADDR_W;
  localparam int OFF_ALU  = OFF_ZERO + 1;
  localparam int PAY_W    = OFF_ALU + DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [PAY_W-1:0]   main_q,      main_d;
  logic [PAY_W-1:0]   skid_q,      skid_d;
  logic               out_valid_q, out_valid_d;
  logic               end_q,       end_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [PAY_W-1:0]   in_payload;
  logic               in_fire;
  logic               out_fire;
  logic               stall_sat;

  assign in_payload = {in_alu, in_zero, in_addr_dest, in_wr_data, in_ctrl, in_opcode};

  // in_ready looks only at registered state plus reset and db_ena, so there
  // is no combinational path from out_ready back to upstream.
  assign in_ready  = reset & db_ena & (state_q != ST_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready & db_ena;
  assign stall_sat = (stall_cnt_q == {STALL_W{1'b1}});

  // Next-state and datapath moves. Flush wins over both handshakes; with
  // db_ena low every register simply holds.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    end_d       = end_q;
    stall_cnt_d = stall_cnt_q;

    if (db_ena) begin
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d = ST_ONE;
              main_d  = in_payload;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_d = in_payload;
            end else if (in_fire) begin
              state_d = ST_FULL;
              skid_d  = in_payload;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (out_fire) begin
              state_d = ST_ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end

      // The end marker is recorded by any accepted word, even on a flush
      // edge, and is never cleared except by reset.
      if (in_fire && in_end) begin
        end_d = 1'b1;
      end

      if (in_valid && !in_ready && !stall_sat) begin
        stall_cnt_d = stall_cnt_q + {{(STALL_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // out_valid is registered from the next state so it tracks the state
  // register exactly and never sees in_valid combinationally.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
  end

  // All state registers, falling-edge clocked with async active-low reset.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      end_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      end_q       <= end_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Occupancy is a direct decode of the state register.
  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_EMPTY: occupancy = 2'd0;
      ST_ONE:   occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  assign out_valid     = out_valid_q;
  assign out_alu       = main_q[OFF_ALU +: DATA_W];
  assign out_zero      = main_q[OFF_ZERO];
  assign out_addr_dest = main_q[OFF_ADDR +: ADDR_W];
  assign out_wr_data   = main_q[OFF_WD +: DATA_W];
  assign out_opcode    = main_q[0 +: OP_W];
  // A bubble must not trigger a memory or register-file write downstream.
  assign out_ctrl      = out_valid_q ? main_q[OFF_CTRL +: CTRL_W] : {CTRL_W{1'b0}};
  assign out_end       = end_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [4:0]  ctrl;
    logic [5:0]  op;
  } pl_t;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        db_ena = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_alu = '0;
  logic        in_zero = 1'b0;
  logic [4:0]  in_addr_dest = '0;
  logic [31:0] in_wr_data = '0;
  logic [4:0]  in_ctrl = '0;
  logic [5:0]  in_opcode = '0;
  logic        in_end = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_zero, out_end;
  logic [31:0] out_alu, out_wr_data;
  logic [4:0]  out_addr_dest, out_ctrl;
  logic [5:0]  out_opcode;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_out_zero, s_out_end;
  logic [31:0] s_out_alu, s_out_wr_data;
  logic [4:0]  s_out_addr_dest, s_out_ctrl;
  logic [5:0]  s_out_opcode;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  pl_t mq[$];
  bit  m_end = 0;
  int  m_stall = 0;
  int  m_stall4 = 0;

  always #5 clk = ~clk;

  pipe_stage_buf dut (
    .clk(clk), .reset(reset), .db_ena(db_ena), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_zero(in_zero), .in_addr_dest(in_addr_dest),
    .in_wr_data(in_wr_data), .in_ctrl(in_ctrl), .in_opcode(in_opcode), .in_end(in_end),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_zero(out_zero), .out_addr_dest(out_addr_dest),
    .out_wr_data(out_wr_data), .out_ctrl(out_ctrl), .out_opcode(out_opcode),
    .out_end(out_end), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.STALL_W(4)) dut4 (
    .clk(clk), .reset(reset), .db_ena(db_ena), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_alu(in_alu), .in_zero(in_zero), .in_addr_dest(in_addr_dest),
    .in_wr_data(in_wr_data), .in_ctrl(in_ctrl), .in_opcode(in_opcode), .in_end(in_end),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_alu(s_out_alu), .out_zero(s_out_zero), .out_addr_dest(s_out_addr_dest),
    .out_wr_data(s_out_wr_data), .out_ctrl(s_out_ctrl), .out_opcode(s_out_opcode),
    .out_end(s_out_end), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (other payload fields derived from alu), then
  // wait for the falling edge and settle.
  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic e,
                               input logic rdy, input logic fl, input logic ena);
    in_valid     = v;
    in_alu       = alu;
    in_zero      = alu[0];
    in_addr_dest = alu[4:0] ^ 5'h15;
    in_wr_data   = alu ^ 32'hFFFF_0000;
    in_ctrl      = alu[4:0] | 5'h01;
    in_opcode    = alu[13:8] ^ 6'h2A;
    in_end       = e;
    out_ready    = rdy;
    flush        = fl;
    db_ena       = ena;
    @(negedge clk);
    #1;
  endtask

  // Behavioural model: a FIFO of at most two words plus counters.
  always @(negedge clk or negedge reset) begin
    bit rdy, fin, fout;
    pl_t cur;
    if (!reset) begin
      mq.delete();
      m_end = 0;
      m_stall = 0;
      m_stall4 = 0;
    end else if (db_ena) begin
      rdy  = (mq.size() < 2);
      fin  = in_valid && rdy;
      fout = (mq.size() > 0) && out_ready;
      cur  = '{in_alu, in_zero, in_addr_dest, in_wr_data, in_ctrl, in_opcode};
      if (in_valid && !rdy) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (fin && in_end) m_end = 1;
      if (flush) mq.delete();
      else begin
        if (fout) void'(mq.pop_front());
        if (fin) mq.push_back(cur);
      end
    end
  end

  // Cycle-by-cycle comparison mid-cycle, away from the falling active edge.
  always @(posedge clk) begin
    pl_t h;
    checkOutput("cyc in_ready", {63'd0, in_ready}, {63'd0, reset && db_ena && (mq.size() < 2)});
    checkOutput("cyc out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    checkOutput("cyc occupancy", {62'd0, occupancy}, 64'(mq.size()));
    checkOutput("cyc out_end", {63'd0, out_end}, {63'd0, m_end});
    checkOutput("cyc stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
    checkOutput("cyc stall_cnt4", {60'd0, s_stall_cnt}, 64'(m_stall4));
    checkOutput("cyc occupancy4", {62'd0, s_occupancy}, 64'(mq.size()));
    if (mq.size() > 0) begin
      h = mq[0];
      checkOutput("cyc out_alu", {32'd0, out_alu}, {32'd0, h.alu});
      checkOutput("cyc out_zero", {63'd0, out_zero}, {63'd0, h.zero});
      checkOutput("cyc out_addr", {59'd0, out_addr_dest}, {59'd0, h.addr});
      checkOutput("cyc out_wr_data", {32'd0, out_wr_data}, {32'd0, h.wd});
      checkOutput("cyc out_ctrl", {59'd0, out_ctrl}, {59'd0, h.ctrl});
      checkOutput("cyc out_opcode", {58'd0, out_opcode}, {58'd0, h.op});
    end else begin
      checkOutput("cyc out_ctrl bubble", {59'd0, out_ctrl}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    // Reset state
    applyStimulus(1'b1, 32'h0000_0099, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0099, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("rst out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst occupancy", {62'd0, occupancy}, 64'd0);
    checkOutput("rst out_ctrl", {59'd0, out_ctrl}, 64'd0);
    checkOutput("rst out_alu", {32'd0, out_alu}, 64'd0);
    checkOutput("rst stall_cnt", {48'd0, stall_cnt}, 64'd0);
    checkOutput("rst out_end", {63'd0, out_end}, 64'd0);
    reset = 1'b1;

    // First word after reset, one-edge latency
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("lat out_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("lat out_alu", {32'd0, out_alu}, 64'h10);
    checkOutput("lat occupancy", {62'd0, occupancy}, 64'd1);
    // Simultaneous in/out in ONE replaces MAIN
    applyStimulus(1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("pass out_alu", {32'd0, out_alu}, 64'h20);
    checkOutput("pass occupancy", {62'd0, occupancy}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("drain occupancy", {62'd0, occupancy}, 64'd0);

    // Back-to-back A, B, C with downstream stalled
    applyStimulus(1'b1, 32'h0000_0A0A, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0B0B, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("full occupancy", {62'd0, occupancy}, 64'd2);
    checkOutput("full in_ready", {63'd0, in_ready}, 64'd0);
    applyStimulus(1'b1, 32'h0000_0C0C, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stall one", {48'd0, stall_cnt}, 64'd1);
    applyStimulus(1'b1, 32'h0000_0C0C, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stall two", {48'd0, stall_cnt}, 64'd2);
    checkOutput("order first A", {32'd0, out_alu}, 64'h0A0A);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("order second B", {32'd0, out_alu}, 64'h0B0B);
    checkOutput("order occupancy", {62'd0, occupancy}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("order empty", {62'd0, occupancy}, 64'd0);

    // Flush while FULL with a word offered
    applyStimulus(1'b1, 32'h0000_0D0D, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0E0E, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0F0F, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("flush occupancy", {62'd0, occupancy}, 64'd0);
    checkOutput("flush out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("flush out_ctrl", {59'd0, out_ctrl}, 64'd0);
    checkOutput("flush stall", {48'd0, stall_cnt}, 64'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("flush no late word", {63'd0, out_valid}, 64'd0);

    // Debug freeze
    applyStimulus(1'b1, 32'h0000_1111, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0000_2222, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("freeze in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("freeze out_alu", {32'd0, out_alu}, 64'h1111);
      checkOutput("freeze occupancy", {62'd0, occupancy}, 64'd1);
      checkOutput("freeze stall", {48'd0, stall_cnt}, 64'd3);
    end
    applyStimulus(1'b1, 32'h0000_3333, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("unfreeze out_alu", {32'd0, out_alu}, 64'h3333);

    // Long stall: 16-bit counter keeps counting, 4-bit one saturates
    applyStimulus(1'b1, 32'h0000_4444, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sat stall16", {48'd0, stall_cnt}, 64'd23);
    checkOutput("sat stall4", {60'd0, s_stall_cnt}, 64'd15);
    applyStimulus(1'b1, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sat stall4 hold", {60'd0, s_stall_cnt}, 64'd15);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("drain order", {32'd0, out_alu}, 64'h4444);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Sticky end flag
    applyStimulus(1'b1, 32'h0000_6666, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("end set", {63'd0, out_end}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("end after flush", {63'd0, out_end}, 64'd1);
    applyStimulus(1'b1, 32'h0000_7777, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("end after traffic", {63'd0, out_end}, 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("async end clear", {63'd0, out_end}, 64'd0);
    checkOutput("async occupancy", {62'd0, occupancy}, 64'd0);
    checkOutput("async out_valid", {63'd0, out_valid}, 64'd0);
    #1 reset = 1'b1;
    applyStimulus(1'b1, 32'h0000_8888, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("post-rst out_alu", {32'd0, out_alu}, 64'h8888);
    checkOutput("post-rst occupancy", {62'd0, occupancy}, 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
